// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit
// Brief   : Pipeline hazard controller - E-stage forwarding, load-use stall,
//           branch flush, multi-cycle memory freeze, stall/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [1:0]            ResultSrcE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MemAccessM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int CNT_BITS = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CNT_BITS-1:0] c_WAIT_LOAD =
        CNT_BITS'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);
    localparam logic c_MEM_MULTI = (MEM_LATENCY > 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_nextCnt;
    logic                w_memStall;
    logic                w_lwStall;
    logic                w_stallF;
    logic                w_flushD;
    logic [CNT_W-1:0]    r_stallCycles;
    logic [CNT_W-1:0]    r_flushCount;

    // M stage wins over W; register x0 is never a forwarding source.
    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_lwStall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // WAIT deliberately ignores MemAccessM, so back-to-back ops each pay full latency.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_memStall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemAccessM && c_MEM_MULTI) begin
                    w_memStall  = 1'b1;
                    w_nextCnt   = c_WAIT_LOAD;
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_memStall = 1'b1;
                    w_nextCnt  = r_cnt - 1'b1;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // A branch resolved during a memory freeze stays in E and flushes once released.
    assign w_stallF = !rst && (w_lwStall || w_memStall);
    assign w_flushD = !rst && PCSrcE && !w_memStall;

    assign ForwardAE = rst ? 2'b00 : fwdSel(Rs1E);
    assign ForwardBE = rst ? 2'b00 : fwdSel(Rs2E);
    assign StallF    = w_stallF;
    assign StallD    = w_stallF;
    assign StallE    = !rst && w_memStall;
    assign StallM    = !rst && w_memStall;
    assign FlushW    = !rst && w_memStall;
    assign FlushD    = w_flushD;
    assign FlushE    = !rst && (PCSrcE || w_lwStall) && !w_memStall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (w_stallF && (r_stallCycles != '1))
                r_stallCycles <= r_stallCycles + 1'b1;
            if (w_flushD && (r_flushCount != '1))
                r_flushCount <= r_flushCount + 1'b1;
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_unit
// Brief   : Directed bench for hazard_unit (single-cycle and 3-cycle memory
//           instances) with a cycle-level reference model and literal checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
    logic [4:0] RdE = '0, RdM = '0, RdW = '0;
    logic [1:0] ResultSrcE = '0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0, MemAccessM = 1'b0;

    logic [1:0]  FA0, FB0, FA3, FB3;
    logic        SF0, SD0, SE0, SM0, FD0, FE0, FW0;
    logic        SF3, SD3, SE3, SM3, FD3, FE3, FW3;
    logic [31:0] sc0, fc0;
    logic [2:0]  sc3, fc3;

    int total = 0;
    int bad   = 0;

    // Model state: cycles remaining in the current memory op (stall cycles + one release cycle).
    int    busy0 = 0, busy3 = 0;
    longint msc0 = 0, mfc0 = 0, msc3 = 0, mfc3 = 0;

    localparam longint MAX0 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX3 = 7;

    hazard_unit #(.REG_ADDR_W(5), .MEM_LATENCY(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .ForwardAE(FA0), .ForwardBE(FB0),
        .StallF(SF0), .StallD(SD0), .StallE(SE0), .StallM(SM0),
        .FlushD(FD0), .FlushE(FE0), .FlushW(FW0),
        .stall_cycles(sc0), .flush_count(fc0)
    );

    hazard_unit #(.REG_ADDR_W(5), .MEM_LATENCY(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .ForwardAE(FA3), .ForwardBE(FB3),
        .StallF(SF3), .StallD(SD3), .StallE(SE3), .StallM(SM3),
        .FlushD(FD3), .FlushE(FE3), .FlushW(FW3),
        .stall_cycles(sc3), .flush_count(fc3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] expFwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {FA,FB,StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [10:0] expOut(input int lat, input int busy);
        logic mem, lw;
        if (rst) return '0;
        mem = (busy > 0) ? (busy > 1) : (MemAccessM && lat > 0);
        lw  = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
        return {expFwd(Rs1E), expFwd(Rs2E), lw | mem, lw | mem, mem, mem,
                PCSrcE & !mem, (PCSrcE | lw) & !mem, mem};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy0 <= 0; busy3 <= 0;
            msc0 <= 0; mfc0 <= 0; msc3 <= 0; mfc3 <= 0;
        end else begin
            logic [10:0] e0, e3;
            e0 = expOut(0, busy0);
            e3 = expOut(3, busy3);
            if (e0[6] && msc0 < MAX0) msc0 <= msc0 + 1;
            if (e0[2] && mfc0 < MAX0) mfc0 <= mfc0 + 1;
            if (e3[6] && msc3 < MAX3) msc3 <= msc3 + 1;
            if (e3[2] && mfc3 < MAX3) mfc3 <= mfc3 + 1;
            busy0 <= 0;
            if (busy3 > 0) busy3 <= busy3 - 1;
            else if (MemAccessM) busy3 <= 3;
        end
    end

    always @(negedge clk) begin
        check("lat0 controls", {FA0, FB0, SF0, SD0, SE0, SM0, FD0, FE0, FW0}, expOut(0, busy0));
        check("lat0 stall_cycles", sc0, msc0);
        check("lat0 flush_count", fc0, mfc0);
        check("lat3 controls", {FA3, FB3, SF3, SD3, SE3, SM3, FD3, FE3, FW3}, expOut(3, busy3));
        check("lat3 stall_cycles", sc3, msc3);
        check("lat3 flush_count", fc3, mfc3);
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemAccessM = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset forces outputs low even with a forwarding hazard present
        RdM = 5; Rs1E = 5; RegWriteM = 1; ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        @(negedge clk);
        check("reset ForwardAE", FA0, 0);
        check("reset StallF", SF0, 0);
        check("reset stall_cycles", sc0, 0);

        go(); rst = 0; clearIn();
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        @(negedge clk);
        check("fwd M priority", FA0, 2'b10);
        go(); RegWriteM = 0;
        @(negedge clk);
        check("fwd W", FA0, 2'b01);
        go(); RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
        @(negedge clk);
        check("fwd x0", FA0, 2'b00);
        go(); RdM = 7; RdW = 7; Rs2E = 7;
        @(negedge clk);
        check("fwd B M", FB0, 2'b10);

        go(); clearIn(); ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        @(negedge clk);
        check("lw StallF", SF0, 1);
        check("lw StallD", SD0, 1);
        check("lw FlushE", FE0, 1);
        check("lw StallE", SE0, 0);
        check("lw count before", sc0, 0);
        go(); clearIn();
        @(negedge clk);
        check("lw StallF released", SF0, 0);
        check("lw count after", sc0, 1);

        go(); PCSrcE = 1;
        @(negedge clk);
        check("br FlushD", FD0, 1);
        check("br FlushE", FE0, 1);
        check("br StallF", SF0, 0);
        go(); clearIn();
        @(negedge clk);
        check("br flush_count", fc0, 1);

        for (int i = 0; i < 4; i++) begin
            go(); MemAccessM = 1;
            @(negedge clk);
            check("mem4 StallM", SM3, (i < 3) ? 1 : 0);
            check("mem4 FlushW", FW3, (i < 3) ? 1 : 0);
            check("mem4 lat0 StallF", SF0, 0);
        end
        go(); clearIn();
        for (int i = 0; i < 8; i++) begin
            go(); MemAccessM = 1;
            @(negedge clk);
            check("mem8 StallF", SF3, (i % 4 != 3) ? 1 : 0);
        end
        go(); clearIn();
        @(negedge clk);
        check("stall_cycles saturated", sc3, 7);

        for (int i = 0; i < 4; i++) begin
            go(); PCSrcE = 1; MemAccessM = (i == 0);
            @(negedge clk);
            check("deferred FlushD", FD3, (i == 3) ? 1 : 0);
            check("deferred FlushE", FE3, (i == 3) ? 1 : 0);
        end
        go(); clearIn();

        go(); MemAccessM = 1;
        @(negedge clk);
        check("abort stall c1", SF3, 1);
        go(); MemAccessM = 0;
        #1;
        check("abort stall c2", SF3, 1);
        rst = 1;
        #1;
        check("abort StallF", SF3, 0);
        check("abort FlushW", FW3, 0);
        check("abort stall_cycles", sc3, 0);
        check("abort flush_count", fc3, 0);
        rst = 0;
        @(negedge clk);
        check("abort idle", SF3, 0);
        for (int i = 0; i < 4; i++) begin
            go(); MemAccessM = (i == 0);
            @(negedge clk);
            check("post-abort StallE", SE3, (i < 3) ? 1 : 0);
        end
        go(); clearIn();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
